// File: rtl/gate_check_pkg.sv
// Shared types and reference truth tables for the gate vector checker.
// Truth-table bit k is the expected gate output for input vector k.
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } gc_state_t;

    localparam logic [3:0] AND2_TT = 4'b1000;
    localparam logic [3:0] OR2_TT  = 4'b1110;
    localparam logic [3:0] XOR2_TT = 4'b0110;

    // Saturating increment for the mismatch counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val == max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/gate_vector_checker_settle_timer.sv
// Loadable down-counter that measures how long each vector settles.
// zero is asserted while the count is 0; the counter parks there until reloaded.
module settle_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/gate_vector_checker.sv
// Sweeps every input vector through an external gate, samples its output after a
// settle window and compares against EXPECT_TT, reporting errors and first failure.
module gate_vector_checker
    import gate_check_pkg::*;
#(
    parameter int                  N_IN       = 2,
    parameter int                  SETTLE_CYC = 4,
    parameter logic [2**N_IN-1:0]  EXPECT_TT  = AND2_TT,
    parameter int                  ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N_IN-1:0]  vec_o,
    input  logic             y_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [N_IN-1:0]  first_fail_vec,
    output logic             first_fail_vld
);

    localparam int              TW       = $clog2(SETTLE_CYC + 1);
    localparam logic [TW-1:0]   RELOAD   = TW'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0] VEC_LAST = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    gc_state_t        state_d, state_q;
    logic [N_IN-1:0]  vec_d, vec_q;
    logic [ERR_W-1:0] err_d, err_q;
    logic [N_IN-1:0]  ffv_d, ffv_q;
    logic             ffvld_d, ffvld_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             pass_d, pass_q;

    logic tmr_load;
    logic tmr_en;
    logic tmr_zero;
    logic mismatch;

    settle_timer #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .en      (tmr_en),
        .load_val(RELOAD),
        .zero    (tmr_zero)
    );

    assign tmr_en   = (state_q == SETTLE);
    assign mismatch = (y_i != EXPECT_TT[vec_q]);

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        err_d    = err_q;
        ffv_d    = ffv_q;
        ffvld_d  = ffvld_q;
        tmr_load = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = SETTLE;
                    vec_d    = '0;
                    err_d    = '0;
                    ffv_d    = '0;
                    ffvld_d  = 1'b0;
                    tmr_load = 1'b1;
                end
            end
            SETTLE: begin
                if (tmr_zero) begin
                    if (mismatch) begin
                        err_d = ERR_W'(sat_inc(32'(err_q), 32'(ERR_MAX)));
                        if (!ffvld_q) begin
                            ffv_d   = vec_q;
                            ffvld_d = 1'b1;
                        end
                    end
                    // The last vector stays on vec_o while the result is reported.
                    if (vec_q == VEC_LAST) begin
                        state_d = DONE;
                    end else begin
                        vec_d    = vec_q + 1'b1;
                        tmr_load = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags follow the next state so pass agrees with err_cnt in the same cycle.
        busy_d = (state_d == SETTLE);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            ffv_q   <= '0;
            ffvld_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffvld_q <= ffvld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign vec_o          = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_q;
    assign first_fail_vec = ffv_q;
    assign first_fail_vld = ffvld_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench: four checker instances (and2 good, wrong table, stuck-at-1, and3 with a
// 2-bit saturating counter) share clock, reset and start.
module tb_gate_vector_checker;
    import gate_check_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // and2, correct table
    logic [1:0] a_vec; logic a_y, a_busy, a_done, a_pass, a_vld; logic [7:0] a_err; logic [1:0] a_ffv;
    assign a_y = a_vec[0] & a_vec[1];
    gate_vector_checker #(.N_IN(2), .SETTLE_CYC(4), .EXPECT_TT(AND2_TT), .ERR_W(8)) u_and (
        .clk(clk), .rst(rst), .start(start), .vec_o(a_vec), .y_i(a_y), .busy(a_busy),
        .done(a_done), .pass(a_pass), .err_cnt(a_err), .first_fail_vec(a_ffv), .first_fail_vld(a_vld));

    // and2, table 4'b1001
    logic [1:0] b_vec; logic b_y, b_busy, b_done, b_pass, b_vld; logic [7:0] b_err; logic [1:0] b_ffv;
    assign b_y = b_vec[0] & b_vec[1];
    gate_vector_checker #(.N_IN(2), .SETTLE_CYC(4), .EXPECT_TT(4'b1001), .ERR_W(8)) u_bad_tt (
        .clk(clk), .rst(rst), .start(start), .vec_o(b_vec), .y_i(b_y), .busy(b_busy),
        .done(b_done), .pass(b_pass), .err_cnt(b_err), .first_fail_vec(b_ffv), .first_fail_vld(b_vld));

    // stuck-at-1 gate
    logic [1:0] s_vec; logic s_busy, s_done, s_pass, s_vld; logic [7:0] s_err; logic [1:0] s_ffv;
    gate_vector_checker #(.N_IN(2), .SETTLE_CYC(4), .EXPECT_TT(AND2_TT), .ERR_W(8)) u_stuck (
        .clk(clk), .rst(rst), .start(start), .vec_o(s_vec), .y_i(1'b1), .busy(s_busy),
        .done(s_done), .pass(s_pass), .err_cnt(s_err), .first_fail_vec(s_ffv), .first_fail_vld(s_vld));

    // and3 vs inverted table, 2-bit counter
    logic [2:0] t_vec; logic t_y, t_busy, t_done, t_pass, t_vld; logic [1:0] t_err; logic [2:0] t_ffv;
    assign t_y = &t_vec;
    gate_vector_checker #(.N_IN(3), .SETTLE_CYC(4), .EXPECT_TT(~(8'b1000_0000)), .ERR_W(2)) u_and3 (
        .clk(clk), .rst(rst), .start(start), .vec_o(t_vec), .y_i(t_y), .busy(t_busy),
        .done(t_done), .pass(t_pass), .err_cnt(t_err), .first_fail_vec(t_ffv), .first_fail_vld(t_vld));

    // Scoreboard of expected vec_o values for u_and, one entry per busy cycle.
    logic [1:0] vec_q[$];
    logic       mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en && a_busy) begin
            if (vec_q.size() == 0) begin
                check("vec_overrun", 32'(a_vec), 32'hFFFF_FFFF);
            end else begin
                logic [1:0] e;
                e = vec_q.pop_front();
                check("vec_seq", 32'(a_vec), 32'(e));
            end
        end
    end

    typedef struct {
        string      name;
        logic [7:0] err;
        logic [7:0] ffv;
        logic       vld;
        logic       pass;
        logic       done;
    } exp_t;
    exp_t tbl[4];

    // Drives a start pulse across one edge and loads the expected vector sequence.
    task automatic kick_sweep();
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 16; i++) vec_q.push_back(2'(i / 4));
        mon_en = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_table();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] err, ffv;
            logic       vld, ps, dn;
            case (i)
                0: begin err = a_err;        ffv = 8'(a_ffv); vld = a_vld; ps = a_pass; dn = a_done; end
                1: begin err = b_err;        ffv = 8'(b_ffv); vld = b_vld; ps = b_pass; dn = b_done; end
                2: begin err = s_err;        ffv = 8'(s_ffv); vld = s_vld; ps = s_pass; dn = s_done; end
                default: begin err = 8'(t_err); ffv = 8'(t_ffv); vld = t_vld; ps = t_pass; dn = t_done; end
            endcase
            check({tbl[i].name, "_done"}, 32'(dn), 32'(tbl[i].done));
            check({tbl[i].name, "_err"}, 32'(err), 32'(tbl[i].err));
            check({tbl[i].name, "_ffv"}, 32'(ffv), 32'(tbl[i].ffv));
            check({tbl[i].name, "_vld"}, 32'(vld), 32'(tbl[i].vld));
            check({tbl[i].name, "_pass"}, 32'(ps), 32'(tbl[i].pass));
        end
    endtask

    initial begin
        tbl[0] = '{"and2", 8'd0, 8'd0, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{"tt1001", 8'd1, 8'd0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{"stuck1", 8'd3, 8'd0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{"and3_sat", 8'd3, 8'd0, 1'b1, 1'b0, 1'b1};

        // Reset for three cycles, then check reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_vec", 32'(a_vec), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_pass", 32'(a_pass), 32'd0);
        check("rst_err", 32'(s_err), 32'd0);
        check("rst_vld", 32'(s_vld), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // First sweep: done exactly 16 cycles after the start edge.
        kick_sweep();
        repeat (16) @(negedge clk);
        check("sweep1_done_early", 32'(a_done), 32'd0);
        @(negedge clk);
        check("sweep1_done", 32'(a_done), 32'd1);
        check("sweep1_pass", 32'(a_pass), 32'd1);
        check("sweep1_busy", 32'(a_busy), 32'd0);
        check("sweep1_vec_hold", 32'(a_vec), 32'd3);
        check("sweep1_sb_empty", 32'(vec_q.size()), 32'd0);
        repeat (20) @(negedge clk);
        mon_en = 1'b0;
        check_table();

        // Restart from DONE, with a start re-pulse in the middle of the sweep.
        kick_sweep();
        @(negedge clk);
        check("restart_err_clr", 32'(s_err), 32'd0);
        check("restart_vld_clr", 32'(s_vld), 32'd0);
        check("restart_busy", 32'(s_busy), 32'd1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("repulse_done_early", 32'(a_done), 32'd0);
        @(negedge clk);
        check("repulse_done", 32'(a_done), 32'd1);
        check("repulse_stuck_err", 32'(s_err), 32'd3);
        check("repulse_sb_empty", 32'(vec_q.size()), 32'd0);
        repeat (20) @(negedge clk);
        mon_en = 1'b0;
        check_table();

        // Asynchronous reset between edges in the middle of a sweep.
        kick_sweep();
        mon_en = 1'b0;
        vec_q.delete();
        repeat (9) @(posedge clk);
        #3;
        check("pre_rst_err", 32'(s_err), 32'd2);
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(s_busy), 32'd0);
        check("arst_vec", 32'(s_vec), 32'd0);
        check("arst_err", 32'(s_err), 32'd0);
        check("arst_vld", 32'(s_vld), 32'd0);
        check("arst_done", 32'(s_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_busy", 32'(a_busy), 32'd0);
        check("post_rst_done", 32'(a_done), 32'd0);
        check("post_rst_vec", 32'(a_vec), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
